// File: rtl/prbs9_pkg.sv
// Shared PRBS9 definitions: checker state encoding and x^9+x^5+1 register geometry.
// The generator uses the same constants so both ends agree on the polynomial.
package prbs9_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEED   = 2'd1,
    ST_VERIFY = 2'd2,
    ST_LOCKED = 2'd3
  } state_e;

  localparam int PRBS9_LEN   = 9;
  localparam int PRBS9_TAP_A = 8;
  localparam int PRBS9_TAP_B = 4;

endpackage

// File: rtl/prbs9_lfsr_step.sv
// Combinational PRBS9 step: prediction from the taps and the shifted register.
// The shifted-in bit is either the prediction (free-running) or an external bit (seeding).
module prbs9_lfsr_step
  import prbs9_pkg::*;
(
  input  logic [PRBS9_LEN-1:0] i_state,
  input  logic                 i_use_pred,
  input  logic                 i_bit,
  output logic                 o_pred,
  output logic [PRBS9_LEN-1:0] o_next
);

  assign o_pred = i_state[PRBS9_TAP_A] ^ i_state[PRBS9_TAP_B];
  assign o_next = {i_state[PRBS9_LEN-2:0], (i_use_pred ? o_pred : i_bit)};

endmodule

// File: rtl/prbs9_checker.sv
// Self-synchronising PRBS9 checker: seeds from the received stream, verifies, locks,
// then counts checked bits and errors, dropping lock when one window sees too many errors.
module prbs9_checker
  import prbs9_pkg::*;
#(
  parameter int LOCK_CNT   = 32,
  parameter int WIN_LEN    = 64,
  parameter int ERR_THRESH = 8,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_enable,
  input  logic             i_valid,
  input  logic             i_bit,
  output logic             o_lock,
  output logic             o_err,
  output logic [CNT_W-1:0] o_bit_count,
  output logic [CNT_W-1:0] o_err_count,
  output logic             o_led
);

  localparam int SEED_W  = $clog2(PRBS9_LEN + 1);
  localparam int MATCH_W = $clog2(LOCK_CNT + 1);
  localparam int WIN_W   = $clog2(WIN_LEN + 1);
  localparam int WERR_W  = $clog2(ERR_THRESH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e                 state_q, state_d;
  logic [PRBS9_LEN-1:0]   s_q, s_d;
  logic [SEED_W-1:0]      seed_cnt_q, seed_cnt_d;
  logic [MATCH_W-1:0]     match_cnt_q, match_cnt_d;
  logic [WIN_W-1:0]       win_cnt_q, win_cnt_d;
  logic [WERR_W-1:0]      win_err_q, win_err_d, win_err_nxt;
  logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]       err_cnt_q, err_cnt_d;
  logic                   lock_q, lock_d;
  logic                   err_q, err_d;
  logic                   led_q, led_d;

  logic                   pred;
  logic [PRBS9_LEN-1:0]   s_step;

  prbs9_lfsr_step u_step (
    .i_state    (s_q),
    .i_use_pred (state_q != ST_SEED),
    .i_bit      (i_bit),
    .o_pred     (pred),
    .o_next     (s_step)
  );

  always_comb begin
    state_d     = state_q;
    s_d         = s_q;
    seed_cnt_d  = seed_cnt_q;
    match_cnt_d = match_cnt_q;
    win_cnt_d   = win_cnt_q;
    win_err_d   = win_err_q;
    win_err_nxt = win_err_q;
    bit_cnt_d   = bit_cnt_q;
    err_cnt_d   = err_cnt_q;
    err_d       = 1'b0;

    if (!i_enable) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d    = ST_SEED;
          seed_cnt_d = '0;
          bit_cnt_d  = '0;
          err_cnt_d  = '0;
        end
        ST_SEED: begin
          if (i_valid) begin
            s_d = s_step;
            if (seed_cnt_q == SEED_W'(PRBS9_LEN - 1)) begin
              state_d     = ST_VERIFY;
              match_cnt_d = '0;
            end else begin
              seed_cnt_d = seed_cnt_q + 1'b1;
            end
          end
        end
        ST_VERIFY: begin
          if (i_valid) begin
            s_d = s_step;
            if (i_bit == pred) begin
              if (match_cnt_q == MATCH_W'(LOCK_CNT - 1)) begin
                state_d   = ST_LOCKED;
                win_cnt_d = '0;
                win_err_d = '0;
              end else begin
                match_cnt_d = match_cnt_q + 1'b1;
              end
            end else begin
              state_d    = ST_SEED;
              seed_cnt_d = '0;
            end
          end
        end
        ST_LOCKED: begin
          if (i_valid) begin
            s_d = s_step;
            if (bit_cnt_q != CNT_MAX) bit_cnt_d = bit_cnt_q + 1'b1;
            if (i_bit != pred) begin
              err_d       = 1'b1;
              win_err_nxt = win_err_q + 1'b1;
              if (err_cnt_q != CNT_MAX) err_cnt_d = err_cnt_q + 1'b1;
            end
            // threshold is judged on this bit's error before any window wrap clears it
            if (win_err_nxt == WERR_W'(ERR_THRESH)) begin
              state_d    = ST_SEED;
              seed_cnt_d = '0;
            end
            if (win_cnt_q == WIN_W'(WIN_LEN - 1)) begin
              win_cnt_d = '0;
              win_err_d = '0;
            end else begin
              win_cnt_d = win_cnt_q + 1'b1;
              win_err_d = win_err_nxt;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    lock_d = (state_d == ST_LOCKED);
    led_d  = lock_d && (err_cnt_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      s_q         <= '0;
      seed_cnt_q  <= '0;
      match_cnt_q <= '0;
      win_cnt_q   <= '0;
      win_err_q   <= '0;
      bit_cnt_q   <= '0;
      err_cnt_q   <= '0;
      lock_q      <= 1'b0;
      err_q       <= 1'b0;
      led_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      seed_cnt_q  <= seed_cnt_d;
      match_cnt_q <= match_cnt_d;
      win_cnt_q   <= win_cnt_d;
      win_err_q   <= win_err_d;
      bit_cnt_q   <= bit_cnt_d;
      err_cnt_q   <= err_cnt_d;
      lock_q      <= lock_d;
      err_q       <= err_d;
      led_q       <= led_d;
    end
  end

  assign o_lock      = lock_q;
  assign o_err       = err_q;
  assign o_bit_count = bit_cnt_q;
  assign o_err_count = err_cnt_q;
  assign o_led       = led_q;

endmodule

// File: doc/prbs9_checker.md
Name: prbs9_checker

Overview:
- Receive-side counterpart of the PRBS9 generator: a self-synchronising checker that takes the recovered bit stream from the receiver's symbol detector.
- Seeds its own LFSR from the incoming bits and qualifies lock.
- Once locked, counts checked bits and bit errors, and declares loss of lock on excessive errors.
- Sits after rx_mod, in place of or alongside ber_mod, so BER is measured without access to the transmitter's generator.

Parameters:
- LOCK_CNT, 32: consecutive matching bits required in VERIFY before declaring lock.
- WIN_LEN, 64: length, in valid bits, of the loss-of-lock observation window.
- ERR_THRESH, 8: errors within one window that force resynchronisation; a window with >= ERR_THRESH errors unlocks.
- CNT_W, 32: width of the bit and error counters.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: synchronous active-high reset.
- i_enable, input, 1: checker enable; low forces IDLE.
- i_valid, input, 1: strobe marking a new received bit (one cycle per symbol, from fsm_mod).
- i_bit, input, 1: received/detected bit, sampled only when i_valid=1.
- o_lock, output, 1: high while in LOCKED.
- o_err, output, 1: one-cycle pulse per mismatched bit while LOCKED.
- o_bit_count, output, CNT_W: bits checked while LOCKED, saturating.
- o_err_count, output, CNT_W: errors counted while LOCKED, saturating.
- o_led, output, 1: LED drive; equals o_lock AND (o_err_count == 0).

Behaviour:
- Polynomial x^9+x^5+1, 9-bit register s[8:0]. Prediction p = s[8]^s[4]. Shift: s <= {s[7:0], b}.
- Reset (clk edge with rst=1): state IDLE, s=0, all counters 0, o_lock=0, o_err=0, o_led=0. Reset mid-operation discards lock and counts immediately.
- All outputs are registered. The state advances only on cycles with i_valid=1, except i_enable=0, which forces IDLE on any cycle.
- IDLE:
  - Counters hold their values.
  - When i_enable=1, go to SEED and clear the seed counter.
- SEED:
  - On each valid: b=i_bit and shift.
  - After 9 valid bits, go to VERIFY with the match counter at 0.
- VERIFY:
  - On each valid: b=p, i.e. free-running.
  - i_bit==p increments the match counter. Reaching LOCK_CNT goes to LOCKED.
  - A mismatch returns to SEED with the seed counter cleared.
- LOCKED:
  - On each valid: b=p, free-running, so errors do not propagate.
  - bit_count+1 per valid. On i_bit!=p: err_count+1, o_err=1 on the next cycle, window error counter +1.
  - Window counter counts valid bits 0..WIN_LEN-1. When it wraps, the window error counter clears.
  - If the window error counter reaches ERR_THRESH, go to SEED. Counters hold; they are not cleared.
- Counter clearing: bit and error counters clear on rst and on the IDLE->SEED transition (a fresh enable).
- Saturation: at 2^CNT_W-1 the counters stop.
- Simultaneous events:
  - Error on the last bit of a window counts toward that window, and the threshold check precedes the window clear.
  - i_enable falling and i_valid in the same cycle: IDLE wins, and the bit is ignored.
- An all-zero seed (s=0 after SEED) never locks by itself on a non-zero stream; the VERIFY mismatch returns it to SEED.
- Latency: o_lock rises on the cycle after the valid carrying the LOCK_CNT-th match. o_err follows its valid by 1 cycle.

Decomposition:
- Shared package holds:
  - state encoding IDLE=2'd0, SEED=2'd1, VERIFY=2'd2, LOCKED=2'd3;
  - PRBS9 length/taps constants (9, taps 8 and 4), which the generator also uses.
- One sub-module, prbs9_lfsr_step: combinational next-state/prediction for the 9-bit register. It is shared with the generator to guarantee identical polynomials.

Test Plan:
- Error-free PRBS9 from the generator with valid every 4 clocks: o_lock rises after 9+32=41 valids; after 1000 further valids, o_bit_count=1000, o_err_count=0, o_led=1.
- Single inverted bit at locked valid #100: one o_err pulse, o_err_count=1, o_lock stays 1, o_led=0, and the next bits produce no further errors (no propagation).
- 8 inverted bits inside one 64-bit window: o_lock falls the cycle after the 8th, counters hold, and relock occurs after 41 clean valids.
- 7 errors in window N plus 7 in window N+1: no unlock, o_err_count=14.
- Bit error during VERIFY at match 20: return to SEED, and lock is delayed by one full 41-valid reacquisition.
- Drop i_enable while LOCKED, then raise it: IDLE then SEED, counters cleared to 0 on re-enable. Separately, rst asserted mid-LOCKED: all outputs 0 next cycle.
